// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_pkg
//  Description : Shared types and constants for the data memory arbiter.
//                Holds the owner encoding, the default bus widths and a
//                helper that sizes a counter to hold a given maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

    // Default data memory geometry.
    localparam int c_addr_size = 5;
    localparam int c_data_size = 32;

    // Which requester drove the memory in a given cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // Number of bits needed to count from 0 up to max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) <= max_val)) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : Bundles the cpu request port, the debug/loader port and the
//                data memory port seen by the arbiter. The slave modport is
//                the arbiter's view; master is the view of the surroundings
//                (pipeline, debug port and memory together).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 32
);
    // cpu (MEM stage) side
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_SIZE-1:0] cpu_addr;
    logic [DATA_SIZE-1:0] cpu_wdata;
    logic                 cpu_stall;
    logic [DATA_SIZE-1:0] cpu_rdata;
    // debug / loader side
    logic                 dbg_req;
    logic                 dbg_we;
    logic [ADDR_SIZE-1:0] dbg_addr;
    logic [DATA_SIZE-1:0] dbg_wdata;
    logic                 dbg_gnt;
    logic [DATA_SIZE-1:0] dbg_rdata;
    logic                 dbg_rvalid;
    // data memory side
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up counter that sticks at MAX instead of wrapping. A clear
//                takes priority over an increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count up on inc, hold once MAX is reached, drop to zero on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt < MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares the single-port data memory between the pipeline MEM
//                stage (cpu, fixed priority) and a debug/loader port (dbg).
//                A starvation counter forces a one-cycle dbg grant after
//                STARVE_LIMIT denied cycles, stalling the cpu for that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE    = c_addr_size,
    parameter int DATA_SIZE    = c_data_size,
    parameter int STARVE_LIMIT = 4,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus,
    output owner_e            owner,
    output logic [STAT_W-1:0] conflict_cnt
);

    // A zero limit leaves the comparison below always true: dbg always wins.
    localparam int                    c_starve_w   = cnt_width(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    logic                  w_gnt_dbg;
    logic                  w_gnt_cpu;
    logic [c_starve_w-1:0] w_starve_cnt;
    logic                  w_mem_we;
    logic [ADDR_SIZE-1:0]  w_mem_addr;
    logic [DATA_SIZE-1:0]  w_mem_wdata;
    owner_e                r_owner;
    owner_e                w_owner_nxt;
    logic [DATA_SIZE-1:0]  r_dbg_rdata;
    logic                  r_dbg_rvalid;

    // Consecutive cycles dbg has been kept waiting; a grant or a withdrawn
    // request starts the wait over.
    sat_counter #(
        .WIDTH (c_starve_w),
        .MAX   (c_starve_max)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_gnt_dbg || !bus.dbg_req),
        .inc   (1'b1),
        .cnt   (w_starve_cnt)
    );

    // Statistics: cycles in which both sides wanted the memory.
    sat_counter #(
        .WIDTH (STAT_W),
        .MAX   ({STAT_W{1'b1}})
    ) u_conflict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (bus.cpu_req && bus.dbg_req),
        .cnt   (conflict_cnt)
    );

    // Grant decision: cpu first unless dbg has waited long enough.
    always_comb begin
        w_gnt_dbg = bus.dbg_req && (!bus.cpu_req || (w_starve_cnt >= c_starve_max));
        w_gnt_cpu = bus.cpu_req && !w_gnt_dbg;
    end

    // Memory mux: only the granted side reaches the memory; idle drives zero.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt_dbg) begin
            w_mem_we    = bus.dbg_we;
            w_mem_addr  = bus.dbg_addr;
            w_mem_wdata = bus.dbg_wdata;
        end else if (w_gnt_cpu) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end
    end

    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // The MEM/WB register captures read data on the same edge, so no flop.
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req && !w_gnt_cpu;
    assign bus.dbg_gnt   = w_gnt_dbg;

    // Owner next-state: who drives the memory this cycle.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_gnt_dbg) begin
            w_owner_nxt = OWN_DBG;
        end else if (w_gnt_cpu) begin
            w_owner_nxt = OWN_CPU;
        end
    end

    // Owner state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign owner = r_owner;

    // dbg reads return one cycle after the grant; reset kills a pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_rdata  <= '0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_dbg_rvalid <= w_gnt_dbg && !bus.dbg_we;
            if (w_gnt_dbg && !bus.dbg_we) begin
                r_dbg_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.dbg_rvalid = r_dbg_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter. dut_a (limit 4)
//                carries the directed and random traffic against a
//                behavioural model; dut_b (limit 0) and dut_c (4-bit
//                statistics counter) cover the parameter corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int LIM_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    data_mem_arbiter_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) bus_a ();
    data_mem_arbiter_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) bus_b ();
    data_mem_arbiter_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) bus_c ();

    owner_e      own_a, own_b, own_c;
    logic [15:0] conf_a, conf_b;
    logic [3:0]  conf_c;

    data_mem_arbiter #(.ADDR_SIZE(5), .DATA_SIZE(32), .STARVE_LIMIT(LIM_A), .STAT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .owner(own_a), .conflict_cnt(conf_a));
    data_mem_arbiter #(.ADDR_SIZE(5), .DATA_SIZE(32), .STARVE_LIMIT(0), .STAT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .owner(own_b), .conflict_cnt(conf_b));
    data_mem_arbiter #(.ADDR_SIZE(5), .DATA_SIZE(32), .STARVE_LIMIT(4), .STAT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c), .owner(own_c), .conflict_cnt(conf_c));

    // Data memory behind dut_a, with a preload port for the bench.
    logic [31:0] mem_a [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_en) mem_a[pre_addr] <= pre_data;
        else if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    end
    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
    // dut_b / dut_c only need some address-dependent read data.
    assign bus_b.mem_rdata = 32'h100 + {27'd0, bus_b.mem_addr};
    assign bus_c.mem_rdata = 32'h200 + {27'd0, bus_c.mem_addr};

    // Reference model for dut_a.
    logic [31:0] m_mem [32];
    int          m_wait;     // consecutive denied dbg cycles
    int          m_conf;
    logic [1:0]  m_owner;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic exp_gd(input logic c, input logic d, input int waited, input int lim);
        return d && (!c || (waited >= lim));
    endfunction

    task automatic model_reset();
        m_wait = 0; m_conf = 0; m_owner = 2'd0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic idle_all();
        bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
        bus_a.dbg_req = 0; bus_a.dbg_we = 0; bus_a.dbg_addr = '0; bus_a.dbg_wdata = '0;
        bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
        bus_b.dbg_req = 0; bus_b.dbg_we = 0; bus_b.dbg_addr = '0; bus_b.dbg_wdata = '0;
        bus_c.cpu_req = 0; bus_c.cpu_we = 0; bus_c.cpu_addr = '0; bus_c.cpu_wdata = '0;
        bus_c.dbg_req = 0; bus_c.dbg_we = 0; bus_c.dbg_addr = '0; bus_c.dbg_wdata = '0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic clock_a();
        logic gd, gc;
        logic [31:0] rd;
        gd = exp_gd(bus_a.cpu_req, bus_a.dbg_req, m_wait, LIM_A);
        gc = bus_a.cpu_req && !gd;
        rd = m_mem[bus_a.dbg_addr];
        if (gd && bus_a.dbg_we) m_mem[bus_a.dbg_addr] = bus_a.dbg_wdata;
        if (gc && bus_a.cpu_we) m_mem[bus_a.cpu_addr] = bus_a.cpu_wdata;
        m_rvalid = gd && !bus_a.dbg_we;
        if (m_rvalid) m_rdata = rd;
        m_owner = gd ? 2'd2 : (gc ? 2'd1 : 2'd0);
        m_wait  = (gd || !bus_a.dbg_req) ? 0 : m_wait + 1;
        if (bus_a.cpu_req && bus_a.dbg_req && m_conf < 65535) m_conf++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clock_a();
        n_checks++; if (own_a !== OWN_NONE) begin n_fail++; $display("FAIL reset owner: got %0d expected 0", own_a); end
        n_checks++; if (conf_a !== 16'd0) begin n_fail++; $display("FAIL reset conflict: got %0d expected 0", conf_a); end
        n_checks++; if (bus_a.dbg_rdata !== 32'd0 || bus_a.dbg_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset dbg_r: got %0h/%0b expected 0/0", bus_a.dbg_rdata, bus_a.dbg_rvalid); end
        // dbg read granted, then reset lands before the capturing edge
        bus_a.dbg_req = 1; bus_a.dbg_we = 0; bus_a.dbg_addr = 5'd7;
        #2;
        n_checks++; if (bus_a.dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL reset pre gnt: got %0b expected 1", bus_a.dbg_gnt); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus_a.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset rvalid: got %0b expected 0", bus_a.dbg_rvalid); end
        n_checks++; if (own_a !== OWN_NONE) begin n_fail++; $display("FAIL reset mid owner: got %0d expected 0", own_a); end
        idle_all();
        #1;
        n_checks++; if ({bus_a.cpu_stall, bus_a.dbg_gnt, bus_a.mem_we} !== 3'b000) begin n_fail++;
            $display("FAIL reset idle outs: got %b expected 000", {bus_a.cpu_stall, bus_a.dbg_gnt, bus_a.mem_we}); end
        rst_n = 1'b1;
        model_reset();
        clock_a();
        n_checks++; if (bus_a.dbg_rvalid !== 1'b0 || own_a !== OWN_NONE || conf_a !== 16'd0) begin n_fail++;
            $display("FAIL reset release: got rvalid %0b owner %0d conf %0d expected 0 0 0", bus_a.dbg_rvalid, own_a, conf_a); end
    endtask

    task automatic test_cpu_only();
        bus_a.cpu_req = 1; bus_a.cpu_we = 1; bus_a.cpu_addr = 5'd3; bus_a.cpu_wdata = 32'hDEADBEEF;
        #2;
        n_checks++; if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 5'd3 || bus_a.mem_wdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL cpu write bus: got we %0b addr %0d data %0h expected 1 3 deadbeef", bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata); end
        n_checks++; if (bus_a.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu write stall: got %0b expected 0", bus_a.cpu_stall); end
        clock_a();
        n_checks++; if (own_a !== OWN_CPU) begin n_fail++; $display("FAIL cpu write owner: got %0d expected 1", own_a); end
        bus_a.cpu_we = 0;
        #2;
        n_checks++; if (bus_a.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu read data: got %0h expected deadbeef", bus_a.cpu_rdata); end
        n_checks++; if (bus_a.cpu_stall !== 1'b0 || bus_a.mem_we !== 1'b0) begin n_fail++;
            $display("FAIL cpu read ctl: got stall %0b we %0b expected 0 0", bus_a.cpu_stall, bus_a.mem_we); end
        clock_a();
        n_checks++; if (own_a !== OWN_CPU) begin n_fail++; $display("FAIL cpu read owner: got %0d expected 1", own_a); end
        idle_all();
    endtask

    task automatic test_dbg_only();
        bus_a.dbg_req = 1; bus_a.dbg_we = 1; bus_a.dbg_addr = 5'd7; bus_a.dbg_wdata = 32'h12345678;
        #2;
        n_checks++; if (bus_a.dbg_gnt !== 1'b1 || bus_a.mem_we !== 1'b1) begin n_fail++;
            $display("FAIL dbg write: got gnt %0b we %0b expected 1 1", bus_a.dbg_gnt, bus_a.mem_we); end
        clock_a();
        n_checks++; if (bus_a.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg write rvalid: got %0b expected 0", bus_a.dbg_rvalid); end
        bus_a.dbg_we = 0;
        #2;
        n_checks++; if (bus_a.dbg_gnt !== 1'b1 || bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 5'd7) begin n_fail++;
            $display("FAIL dbg read bus: got gnt %0b we %0b addr %0d expected 1 0 7", bus_a.dbg_gnt, bus_a.mem_we, bus_a.mem_addr); end
        clock_a();
        bus_a.dbg_req = 0;
        n_checks++; if (bus_a.dbg_rvalid !== 1'b1 || bus_a.dbg_rdata !== 32'h12345678) begin n_fail++;
            $display("FAIL dbg read ret: got %0b/%0h expected 1/12345678", bus_a.dbg_rvalid, bus_a.dbg_rdata); end
        n_checks++; if (own_a !== OWN_DBG) begin n_fail++; $display("FAIL dbg owner: got %0d expected 2", own_a); end
        clock_a();
        n_checks++; if (bus_a.dbg_rvalid !== 1'b0 || own_a !== OWN_NONE) begin n_fail++;
            $display("FAIL dbg after: got rvalid %0b owner %0d expected 0 0", bus_a.dbg_rvalid, own_a); end
    endtask

    task automatic test_back_to_back();
        bus_a.dbg_req = 1; bus_a.dbg_we = 0; bus_a.dbg_addr = 5'd3;
        clock_a();
        bus_a.dbg_addr = 5'd7;
        n_checks++; if (bus_a.dbg_rvalid !== 1'b1 || bus_a.dbg_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL b2b first: got %0b/%0h expected 1/deadbeef", bus_a.dbg_rvalid, bus_a.dbg_rdata); end
        clock_a();
        idle_all();
        n_checks++; if (bus_a.dbg_rvalid !== 1'b1 || bus_a.dbg_rdata !== 32'h12345678) begin n_fail++;
            $display("FAIL b2b second: got %0b/%0h expected 1/12345678", bus_a.dbg_rvalid, bus_a.dbg_rdata); end
        clock_a();
        n_checks++; if (bus_a.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b end: got %0b expected 0", bus_a.dbg_rvalid); end
    endtask

    task automatic test_contention();
        logic exp_d;
        bus_a.dbg_req = 1; bus_a.dbg_we = 0; bus_a.dbg_addr = 5'($urandom_range(0, 31));
        for (int k = 1; k <= 10; k++) begin
            bus_a.cpu_req = 1; bus_a.cpu_we = 1;
            bus_a.cpu_addr = 5'($urandom_range(0, 31)); bus_a.cpu_wdata = $urandom;
            exp_d = ((k % (LIM_A + 1)) == 0);
            #2;
            n_checks++; if (bus_a.dbg_gnt !== exp_d || bus_a.cpu_stall !== exp_d) begin n_fail++;
                $display("FAIL contention cyc %0d: got gnt %0b stall %0b expected %0b", k, bus_a.dbg_gnt, bus_a.cpu_stall, exp_d); end
            n_checks++; if (bus_a.mem_we !== !exp_d || bus_a.mem_addr !== (exp_d ? bus_a.dbg_addr : bus_a.cpu_addr)) begin n_fail++;
                $display("FAIL contention bus cyc %0d: got we %0b addr %0d", k, bus_a.mem_we, bus_a.mem_addr); end
            clock_a();
            if (exp_d) bus_a.dbg_addr = 5'($urandom_range(0, 31));
        end
        idle_all();
        n_checks++; if (conf_a !== 16'd10) begin n_fail++; $display("FAIL contention conflict: got %0d expected 10", conf_a); end
        clock_a();
    endtask

    task automatic test_withdrawal();
        bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 5'd9;
        bus_a.dbg_req = 1; bus_a.dbg_we = 1; bus_a.dbg_addr = 5'd12; bus_a.dbg_wdata = 32'hA5A5A5A5;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus_a.dbg_req = 0;
            #2;
            n_checks++; if (bus_a.dbg_gnt !== 1'b0 || bus_a.mem_addr !== 5'd9 || bus_a.mem_we !== 1'b0) begin n_fail++;
                $display("FAIL withdraw cyc %0d: got gnt %0b addr %0d we %0b expected 0 9 0", k, bus_a.dbg_gnt, bus_a.mem_addr, bus_a.mem_we); end
            clock_a();
        end
        // a cleared wait means the next forced grant is a full window away
        bus_a.dbg_req = 1;
        for (int k = 1; k <= 5; k++) begin
            #2;
            n_checks++; if (bus_a.dbg_gnt !== (k == 5)) begin n_fail++;
                $display("FAIL withdraw regrant cyc %0d: got %0b expected %0b", k, bus_a.dbg_gnt, (k == 5)); end
            clock_a();
        end
        idle_all();
        clock_a();
    endtask

    task automatic test_abs_priority();
        for (int k = 0; k < 6; k++) begin
            bus_b.cpu_req = 1; bus_b.cpu_we = 1'($urandom_range(0, 1)); bus_b.cpu_addr = 5'($urandom_range(0, 31));
            bus_b.dbg_req = 1; bus_b.dbg_we = 1'($urandom_range(0, 1)); bus_b.dbg_addr = 5'($urandom_range(0, 31));
            #2;
            n_checks++; if (bus_b.dbg_gnt !== 1'b1 || bus_b.cpu_stall !== 1'b1) begin n_fail++;
                $display("FAIL abs prio cyc %0d: got gnt %0b stall %0b expected 1 1", k, bus_b.dbg_gnt, bus_b.cpu_stall); end
            n_checks++; if (bus_b.mem_addr !== bus_b.dbg_addr || bus_b.mem_we !== bus_b.dbg_we) begin n_fail++;
                $display("FAIL abs prio bus cyc %0d: got addr %0d we %0b", k, bus_b.mem_addr, bus_b.mem_we); end
            clock_a();
            n_checks++; if (own_b !== OWN_DBG || bus_b.dbg_rvalid !== !bus_b.dbg_we) begin n_fail++;
                $display("FAIL abs prio reg cyc %0d: got owner %0d rvalid %0b", k, own_b, bus_b.dbg_rvalid); end
        end
        idle_all();
        clock_a();
    endtask

    task automatic test_saturation();
        bus_c.cpu_req = 1; bus_c.dbg_req = 1;
        for (int k = 1; k <= 20; k++) begin
            clock_a();
            n_checks++; if (conf_c !== 4'((k > 15) ? 15 : k)) begin n_fail++;
                $display("FAIL saturation cyc %0d: got %0d expected %0d", k, conf_c, (k > 15) ? 15 : k); end
        end
        idle_all();
        clock_a();
    endtask

    task automatic test_random();
        logic gd, gc, hold;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        hold = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!hold) begin
                bus_a.cpu_req = 1'($urandom_range(0, 1)); bus_a.cpu_we = 1'($urandom_range(0, 1));
                bus_a.cpu_addr = 5'($urandom_range(0, 31)); bus_a.cpu_wdata = $urandom;
            end
            if (!bus_a.dbg_req && $urandom_range(0, 2) == 0) begin
                bus_a.dbg_req = 1; bus_a.dbg_we = 1'($urandom_range(0, 1));
                bus_a.dbg_addr = 5'($urandom_range(0, 31)); bus_a.dbg_wdata = $urandom;
            end
            gd = exp_gd(bus_a.cpu_req, bus_a.dbg_req, m_wait, LIM_A);
            gc = bus_a.cpu_req && !gd;
            e_we   = gd ? bus_a.dbg_we    : (gc ? bus_a.cpu_we    : 1'b0);
            e_addr = gd ? bus_a.dbg_addr  : (gc ? bus_a.cpu_addr  : 5'd0);
            e_wd   = gd ? bus_a.dbg_wdata : (gc ? bus_a.cpu_wdata : 32'd0);
            #2;
            n_checks++; if (bus_a.dbg_gnt !== gd || bus_a.cpu_stall !== (bus_a.cpu_req && !gc)) begin n_fail++;
                $display("FAIL random grant cyc %0d: got gnt %0b stall %0b expected %0b %0b", cyc, bus_a.dbg_gnt, bus_a.cpu_stall, gd, bus_a.cpu_req && !gc); end
            n_checks++; if (bus_a.mem_we !== e_we || bus_a.mem_addr !== e_addr || bus_a.mem_wdata !== e_wd) begin n_fail++;
                $display("FAIL random bus cyc %0d: got %0b/%0d/%0h expected %0b/%0d/%0h", cyc, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, e_we, e_addr, e_wd); end
            if (gc && !bus_a.cpu_we) begin
                n_checks++; if (bus_a.cpu_rdata !== m_mem[bus_a.cpu_addr]) begin n_fail++;
                    $display("FAIL random cpu_rdata cyc %0d: got %0h expected %0h", cyc, bus_a.cpu_rdata, m_mem[bus_a.cpu_addr]); end
            end
            hold = bus_a.cpu_req && !gc;
            clock_a();
            if (gd) bus_a.dbg_req = 0;
            n_checks++; if (own_a !== owner_e'(m_owner) || bus_a.dbg_rvalid !== m_rvalid) begin n_fail++;
                $display("FAIL random reg cyc %0d: got owner %0d rvalid %0b expected %0d %0b", cyc, own_a, bus_a.dbg_rvalid, m_owner, m_rvalid); end
            if (m_rvalid) begin
                n_checks++; if (bus_a.dbg_rdata !== m_rdata) begin n_fail++;
                    $display("FAIL random dbg_rdata cyc %0d: got %0h expected %0h", cyc, bus_a.dbg_rdata, m_rdata); end
            end
            n_checks++; if (conf_a !== 16'(m_conf)) begin n_fail++;
                $display("FAIL random conflict cyc %0d: got %0d expected %0d", cyc, conf_a, m_conf); end
        end
        idle_all();
        clock_a();
    endtask

    initial begin
        idle_all();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        // preload the memory while the arbiter sits in reset
        for (int i = 0; i < 32; i++) begin
            pre_en = 1'b1; pre_addr = 5'(i); pre_data = $urandom;
            m_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        test_reset();
        test_cpu_only();
        test_dbg_only();
        test_back_to_back();
        test_contention();
        test_withdrawal();
        test_abs_priority();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (cpu) and a debug/loader port (dbg). The cpu has fixed priority. A starvation counter forces a one-cycle dbg grant after a bounded wait, and the cpu is stalled for that cycle. The block sits between the EX/MEM pipeline registers and the data memory, and its stall output feeds the pipeline stall logic.

Parameters:
ADDR_SIZE, 5, data memory word-address width
DATA_SIZE, 32, data word width
STARVE_LIMIT, 4, consecutive denied dbg cycles before a forced dbg grant; 0 means dbg has absolute priority
STAT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage requests a memory access this cycle
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_SIZE  cpu word address
cpu_wdata  in  DATA_SIZE  cpu write data
cpu_stall  out  1  cpu request not served this cycle; pipeline must hold
cpu_rdata  out  DATA_SIZE  read data, combinational, valid when cpu_req && !cpu_stall && !cpu_we
dbg_req  in  1  dbg request; held with addr/we/wdata stable until dbg_gnt
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_SIZE  dbg word address
dbg_wdata  in  DATA_SIZE  dbg write data
dbg_gnt  out  1  dbg access performed this cycle
dbg_rdata  out  DATA_SIZE  registered read data
dbg_rvalid  out  1  one-cycle pulse, the cycle after a granted dbg read
mem_we  out  1  to data memory write enable
mem_addr  out  ADDR_SIZE  to data memory address (read and write)
mem_wdata  out  DATA_SIZE  to data memory write data
mem_rdata  in  DATA_SIZE  from data memory, combinational read of mem_addr
owner  out  2  registered owner of the previous cycle (owner_e)
conflict_cnt  out  STAT_W  saturating count of cycles where both requested

Behaviour:
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, owner=OWN_NONE, dbg_rdata=0, dbg_rvalid=0, conflict_cnt=0.
  - The combinational outputs resolve to cpu_stall=0, dbg_gnt=0 and mem_we=0 when no request is present.
  - A pending dbg read captured before reset never produces rvalid.
- Grant decision, combinational each cycle:
  - gnt_dbg = dbg_req && (!cpu_req || starve_cnt >= STARVE_LIMIT).
  - gnt_cpu = cpu_req && !gnt_dbg.
  - At most one grant per cycle, so no write collision is possible.
- Outputs derived from the grant:
  - cpu_stall = cpu_req && !gnt_cpu.
  - dbg_gnt = gnt_dbg.
- Memory mux:
  - Granted requester drives mem_we/mem_addr/mem_wdata.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is never 1 without a grant.
- cpu_rdata = mem_rdata (pass-through). It is meaningful only in a cpu-granted read cycle, with zero added latency, because the MEM/WB register captures it at the same edge.
- dbg read: on a posedge with gnt_dbg && !dbg_we, dbg_rdata<=mem_rdata and dbg_rvalid<=1; otherwise dbg_rvalid<=0. Latency is exactly 1 cycle. Back-to-back dbg reads give back-to-back rvalid.
- starve_cnt, at each posedge:
  - if gnt_dbg or !dbg_req: 0
  - else if starve_cnt<STARVE_LIMIT: +1
  - else: hold (saturate).
  - With cpu_req continuous and dbg_req continuous, dbg is granted once every STARVE_LIMIT+1 cycles.
- dbg_req withdrawn before grant: counter clears and no access occurs. This is legal but discouraged.
- owner <= OWN_CPU if gnt_cpu, OWN_DBG if gnt_dbg, else OWN_NONE (state register: NONE/CPU/DBG).
- conflict_cnt: +1 on each cycle with cpu_req && dbg_req; saturates at 2^STAT_W-1 and never wraps.
- The cpu must hold its request while stalled. The arbiter does not buffer cpu requests.

Decomposition:
- Shared package: owner_e (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DBG=2'd2).
- ADDR_SIZE/DATA_SIZE come from the existing global definitions header.
- One sub-module: sat_counter (parameters WIDTH, MAX; inputs clk, rst_n, clr, inc; output cnt). It is instantiated for both starve_cnt and conflict_cnt.

Test Plan:
1. Reset mid-access: rst_n=0 during a dbg read grant -> the next cycle has dbg_rvalid=0; after release, owner=0, conflict_cnt=0, starve_cnt=0.
2. cpu only: write addr 3 data 0xDEADBEEF, then read addr 3 -> mem_we=1 on the write cycle, cpu_stall=0 throughout, cpu_rdata=0xDEADBEEF on the read cycle, owner=1 after each.
3. dbg only: read addr 7 (memory holds 0x12345678) -> dbg_gnt=1 that cycle; next cycle dbg_rvalid=1, dbg_rdata=0x12345678; following cycle dbg_rvalid=0.
4. Contention, STARVE_LIMIT=4, cpu_req and dbg_req held for 10 cycles:
   - dbg_gnt=1 in cycles 5 and 10 only; cpu_stall=1 exactly in those cycles.
   - conflict_cnt=10 afterwards.
   - mem_we never asserted without a grant.
5. Absolute priority, STARVE_LIMIT=0: cpu_req=dbg_req=1 -> dbg_gnt=1 and cpu_stall=1 every cycle.
6. Withdrawal and saturation:
   - dbg_req held 2 contended cycles then dropped -> no dbg access, starve_cnt back to 0.
   - STAT_W=4 with 20 contended cycles -> conflict_cnt=15.
